// File: rtl/pma_tx_ser.sv
// Serializes PCS words (or PRBS7 / clock pattern / electrical idle) onto a registered differential bit stream.
// Mode changes only take effect at word boundaries.
module pma_tx_ser #(
  parameter int DATA_WIDTH = 10,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  Bit_Rate_Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  MAC_Data_En,
  input  logic [1:0]            Mode,
  input  logic                  Polarity_Inv,
  output logic                  Data_Ready,
  output logic                  TX_Out_P,
  output logic                  TX_Out_N,
  output logic                  Elec_Idle,
  output logic                  Underrun
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  // Encodings equal the Mode codes so the boundary update is a plain cast.
  typedef enum logic [1:0] {
    ST_DATA   = 2'b00,
    ST_PRBS   = 2'b01,
    ST_EIDLE  = 2'b10,
    ST_CLKPAT = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [6:0]            lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  clk_bit_q, clk_bit_d;
  logic                  urun_slot_q, urun_slot_d;
  logic                  tx_p_q, tx_p_d;
  logic                  tx_n_q, tx_n_d;
  logic                  eidle_q, eidle_d;
  logic                  underrun_q, underrun_d;

  logic       boundary;
  logic       entering;
  logic       bit_out;
  logic       idle;
  logic [6:0] lfsr_src;

  assign boundary   = (cnt_q == LAST);
  assign Data_Ready = boundary && (Mode == 2'b00) && !Rst;

  always_comb begin
    cnt_d       = boundary ? '0 : cnt_q + CW'(1);
    state_d     = boundary ? state_t'(Mode) : state_q;
    entering    = boundary && (state_d != state_q);
    lfsr_d      = lfsr_q;
    sh_d        = sh_q;
    clk_bit_d   = clk_bit_q;
    urun_slot_d = urun_slot_q;
    underrun_d  = 1'b0;
    bit_out     = 1'b0;
    idle        = 1'b0;
    lfsr_src    = entering ? 7'h7F : lfsr_q;

    case (state_d)
      ST_DATA: begin
        if (boundary) begin
          if (MAC_Data_En) begin
            urun_slot_d = 1'b0;
            if (MSB_FIRST) begin
              bit_out = Data_in[DATA_WIDTH-1];
              sh_d    = Data_in << 1;
            end else begin
              bit_out = Data_in[0];
              sh_d    = Data_in >> 1;
            end
          end else begin
            // Missed slot: the whole word period goes idle.
            urun_slot_d = 1'b1;
            underrun_d  = 1'b1;
            idle        = 1'b1;
          end
        end else if (urun_slot_q) begin
          idle = 1'b1;
        end else if (MSB_FIRST) begin
          bit_out = sh_q[DATA_WIDTH-1];
          sh_d    = sh_q << 1;
        end else begin
          bit_out = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      ST_PRBS: begin
        bit_out = lfsr_src[6];
        lfsr_d  = {lfsr_src[5:0], lfsr_src[6] ^ lfsr_src[5]};
      end
      ST_CLKPAT: begin
        bit_out   = entering ? 1'b1 : ~clk_bit_q;
        clk_bit_d = bit_out;
      end
      default: idle = 1'b1;
    endcase

    tx_p_d  = idle ? 1'b0 : (bit_out ^ Polarity_Inv);
    tx_n_d  = idle ? 1'b0 : ~(bit_out ^ Polarity_Inv);
    eidle_d = idle;
  end

  always_ff @(posedge Bit_Rate_Clk) begin
    if (Rst) begin
      cnt_q       <= LAST;
      state_q     <= ST_EIDLE;
      lfsr_q      <= 7'h7F;
      sh_q        <= '0;
      clk_bit_q   <= 1'b0;
      urun_slot_q <= 1'b0;
      tx_p_q      <= 1'b0;
      tx_n_q      <= 1'b0;
      eidle_q     <= 1'b1;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      sh_q        <= sh_d;
      clk_bit_q   <= clk_bit_d;
      urun_slot_q <= urun_slot_d;
      tx_p_q      <= tx_p_d;
      tx_n_q      <= tx_n_d;
      eidle_q     <= eidle_d;
      underrun_q  <= underrun_d;
    end
  end

  assign TX_Out_P  = tx_p_q;
  assign TX_Out_N  = tx_n_q;
  assign Elec_Idle = eidle_q;
  assign Underrun  = underrun_q;

endmodule

// File: tb/tb_pma_tx_ser.sv
// Bench for pma_tx_ser: directed word table, corner sequences, then random traffic against a word-level queue model.
module tb_pma_tx_ser;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         Rst = 1'b1;
  logic [W-1:0] Data_in = '0;
  logic         MAC_Data_En = 1'b0;
  logic [1:0]   Mode = 2'b00;
  logic         Polarity_Inv = 1'b0;
  logic         Data_Ready, TX_Out_P, TX_Out_N, Elec_Idle, Underrun;

  int checks = 0;
  int errors = 0;

  pma_tx_ser #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .Bit_Rate_Clk(clk),
    .Rst(Rst),
    .Data_in(Data_in),
    .MAC_Data_En(MAC_Data_En),
    .Mode(Mode),
    .Polarity_Inv(Polarity_Inv),
    .Data_Ready(Data_Ready),
    .TX_Out_P(TX_Out_P),
    .TX_Out_N(TX_Out_N),
    .Elec_Idle(Elec_Idle),
    .Underrun(Underrun)
  );

  always #5 clk = ~clk;

  // Word-level reference: at each boundary the model queues the next W output slots.
  typedef struct packed {
    logic idle;
    logic val;
    logic ur;
  } slot_t;

  slot_t q[$];
  bit    model_en = 1'b0;
  int    m_state = 2;
  int    prbs_i = 0;
  int    clk_i = 0;
  bit    prbs_seq[127];
  logic  exp_p, exp_n, exp_ei, exp_ur;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic p, input logic n, input logic ei, input logic ur);
    chk({tag, ".P"}, TX_Out_P, p);
    chk({tag, ".N"}, TX_Out_N, n);
    chk({tag, ".EI"}, Elec_Idle, ei);
    chk({tag, ".UR"}, Underrun, ur);
  endtask

  task automatic model_edge();
    slot_t s;
    bit    entering;
    chk("model.ready", Data_Ready, !Rst && (q.size() == 0) && (Mode == 2'b00));
    if (Rst) begin
      q.delete();
      m_state = 2;
      {exp_p, exp_n, exp_ei, exp_ur} = 4'b0010;
      return;
    end
    if (q.size() == 0) begin
      entering = (int'(Mode) != m_state);
      m_state  = int'(Mode);
      case (Mode)
        2'b00: begin
          for (int i = 0; i < W; i++) begin
            if (MAC_Data_En) q.push_back('{idle: 1'b0, val: Data_in[i], ur: 1'b0});
            else             q.push_back('{idle: 1'b1, val: 1'b0, ur: (i == 0)});
          end
        end
        2'b01: begin
          if (entering) prbs_i = 0;
          for (int i = 0; i < W; i++) begin
            q.push_back('{idle: 1'b0, val: prbs_seq[prbs_i], ur: 1'b0});
            prbs_i = (prbs_i + 1) % 127;
          end
        end
        2'b10: begin
          for (int i = 0; i < W; i++) q.push_back('{idle: 1'b1, val: 1'b0, ur: 1'b0});
        end
        default: begin
          if (entering) clk_i = 0;
          for (int i = 0; i < W; i++) begin
            q.push_back('{idle: 1'b0, val: (clk_i % 2 == 0), ur: 1'b0});
            clk_i++;
          end
        end
      endcase
    end
    s = q.pop_front();
    if (s.idle) {exp_p, exp_n, exp_ei} = 3'b001;
    else begin
      exp_p  = s.val ^ Polarity_Inv;
      exp_n  = ~exp_p;
      exp_ei = 1'b0;
    end
    exp_ur = s.ur;
  endtask

  task automatic tick();
    #1;
    if (model_en) model_edge();
    @(posedge clk);
    #1;
    if (model_en) chk_out("model", exp_p, exp_n, exp_ei, exp_ur);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    MAC_Data_En = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset.ready", Data_Ready, 1'b0);
    Rst = 1'b0;
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!Data_Ready && n < 4 * W) begin
      tick();
      n++;
    end
    chk("ready_wait", Data_Ready, 1'b1);
  endtask

  task automatic send_word(input logic [W-1:0] word, input logic pol, input logic [W-1:0] seq);
    wait_ready();
    Data_in = word;
    MAC_Data_En = 1'b1;
    Polarity_Inv = pol;
    tick();
    MAC_Data_En = 1'b0;
    Data_in = W'($urandom);
    for (int i = 0; i < W; i++) begin
      chk_out($sformatf("word%03h.bit%0d", word, i), seq[W-1-i], ~seq[W-1-i], 1'b0, 1'b0);
      if (i < W - 1) tick();
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         pol;
    logic [W-1:0] seq;  // transmitted P sequence, first bit at the MSB
  } vec_t;

  vec_t tbl[5];
  logic pb[254];

  initial begin
    logic [6:0] l;
    l = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs_seq[i] = l[6];
      l = {l[5:0], l[6] ^ l[5]};
    end

    tbl[0] = '{10'h17C, 1'b0, 10'b0011111010};
    tbl[1] = '{10'h17C, 1'b1, 10'b1100000101};
    tbl[2] = '{10'h001, 1'b0, 10'b1000000000};
    tbl[3] = '{10'h200, 1'b0, 10'b0000000001};
    tbl[4] = '{10'h2AA, 1'b1, 10'b1010101010};

    // Back-to-back DATA words.
    Mode = 2'b00;
    do_reset();
    chk("release.ready", Data_Ready, 1'b1);
    for (int e = 0; e < 5; e++) send_word(tbl[e].word, tbl[e].pol, tbl[e].seq);

    // Underrun slot, then normal traffic resumes.
    wait_ready();
    MAC_Data_En = 1'b0;
    tick();
    chk_out("underrun.0", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < W; i++) begin
      tick();
      chk_out($sformatf("underrun.%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("underrun.ready", Data_Ready, 1'b1);
    send_word(tbl[0].word, tbl[0].pol, tbl[0].seq);

    // Mode to EIDLE mid-word: word completes, idle from next boundary.
    wait_ready();
    Data_in = 10'h17C;
    MAC_Data_En = 1'b1;
    Polarity_Inv = 1'b0;
    tick();
    MAC_Data_En = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk_out($sformatf("modechg.bit%0d", i), tbl[0].seq[W-1-i], ~tbl[0].seq[W-1-i], 1'b0, 1'b0);
      if (i == 4) Mode = 2'b10;
      if (i < W - 1) tick();
    end
    #1;
    chk("modechg.ready", Data_Ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("modechg.idle%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Reset in the middle of a word.
    Mode = 2'b00;
    wait_ready();
    Data_in = 10'h17C;
    MAC_Data_En = 1'b1;
    tick();
    MAC_Data_En = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    Rst = 1'b1;
    tick();
    chk_out("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("midrst.ready", Data_Ready, 1'b0);
    Rst = 1'b0;
    #1;
    chk("midrst.release_ready", Data_Ready, 1'b1);
    send_word(tbl[0].word, tbl[0].pol, tbl[0].seq);

    // PRBS7 from reset.
    Mode = 2'b01;
    do_reset();
    tick();
    for (int i = 0; i < 254; i++) begin
      pb[i] = TX_Out_P;
      if (i < 20) chk($sformatf("prbs.ei%0d", i), Elec_Idle, 1'b0);
      tick();
    end
    for (int i = 0; i < 7; i++) chk($sformatf("prbs.bit%0d", i), pb[i], 1'b1);
    chk("prbs.bit7", pb[7], 1'b0);
    for (int i = 0; i < 127; i++) chk($sformatf("prbs.period%0d", i), pb[i + 127], pb[i]);

    // Clock pattern from reset.
    Mode = 2'b11;
    do_reset();
    tick();
    for (int i = 0; i < 12; i++) begin
      chk_out($sformatf("clkpat.%0d", i), (i % 2 == 0), (i % 2 != 0), 1'b0, 1'b0);
      tick();
    end

    // Random traffic against the reference model.
    Rst = 1'b1;
    model_en = 1'b1;
    tick();
    Rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) Mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) Polarity_Inv = ~Polarity_Inv;
      MAC_Data_En = ($urandom_range(0, 7) != 0);
      Data_in = W'($urandom);
      Rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    model_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
